// File: rtl/kamus_pkg.sv
// kamus_pkg: shared types and helpers for the kamus pipeline memory stage.
package kamus_pkg;

    typedef enum logic [5:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd2,
        OP_AND  = 6'd3,
        OP_OR   = 6'd4,
        OP_XOR  = 6'd5,
        OP_SLL  = 6'd6,
        OP_SRL  = 6'd7,
        OP_SRA  = 6'd8,
        OP_SLT  = 6'd9,
        OP_SLTU = 6'd10,
        OP_LUI  = 6'd11,
        OP_JAL  = 6'd12,
        OP_JALR = 6'd13,
        OP_LB   = 6'd32,
        OP_LH   = 6'd33,
        OP_LW   = 6'd34,
        OP_LBU  = 6'd35,
        OP_LHU  = 6'd36,
        OP_SB   = 6'd40,
        OP_SH   = 6'd41,
        OP_SW   = 6'd42
    } operation_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        operation_e  operation;
        logic [4:0]  rd_addr;
        logic        regfile_wr_en;
        logic [1:0]  wb_mux_sel;
        logic        l1d_wr_en;
    } instr_decoded_t;

    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;

    function automatic logic is_mem_op(input operation_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic op_is_store(input operation_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic op_is_unsigned(input operation_e op);
        return op inside {OP_LBU, OP_LHU};
    endfunction

    function automatic mem_size_e op_size(input operation_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = HALF;
            default:              op_size = WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
        case (size)
            HALF:    is_misaligned = addr_lo[0];
            WORD:    is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// kamus_lsu_align: byte-lane steering for stores and extraction/extension
// for loads. Purely combinational.
module kamus_lsu_align
    import kamus_pkg::*;
(
    input  mem_size_e   size,
    input  logic        store,
    input  logic        unsigned_ld,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    // Store lane enables and replicated write data; loads read the full word.
    always_comb begin
        be    = 4'hF;
        wdata = store_data;
        if (store) begin
            case (size)
                BYTE: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                HALF: begin
                    be    = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata = {2{store_data[15:0]}};
                end
                default: begin
                    be    = 4'hF;
                    wdata = store_data;
                end
            endcase
        end
    end

    // Select the addressed byte/half of the response and sign/zero extend it.
    always_comb begin
        load_data = rdata;
        case (size)
            BYTE:    load_data = unsigned_ld ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            HALF:    load_data = unsigned_ld ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/kamus_mem_stage.sv
// kamus_mem_stage: memory stage between execute and writeback. Runs L1D
// load/store transactions and registers results/exceptions toward WB.
// Build option KAMUS_MISALIGN_TRAP_EN: misaligned H/W accesses trap from IDLE
// (cause 4/6) instead of being issued with forced word alignment.
//
// state | meaning
// IDLE  | ready; non-memory ops and misalign traps retire directly from here
// REQ   | request driven on L1D, outputs held until grant
// RSP   | granted, waiting for response / store ack
module kamus_mem_stage
    import kamus_pkg::*;
#(
    parameter int BUS_TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [5:0]  operation_i,
    input  logic [31:0] ex_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        regfile_wr_en_i,
    input  logic [1:0]  wb_mux_sel_i,
    input  logic        l1d_wr_en_i,
    input  logic [31:0] next_pc_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_err_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic        wb_regfile_wr_en_o,
    output logic [1:0]  wb_mux_sel_o,
    output logic [31:0] wb_ex_o,
    output logic [31:0] wb_load_data_o,
    output logic [31:0] wb_next_pc_o,
    output logic        exc_o,
    output logic [3:0]  exc_cause_o,
    output logic [31:0] exc_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    // The counter only ever holds 0 .. BUS_TIMEOUT_CYCLES-1; the fault fires
    // in the last allowed cycle so the request is live for exactly that many.
    localparam bit              TMO_EN   = (BUS_TIMEOUT_CYCLES != 0);
    localparam int              CNT_W    = (BUS_TIMEOUT_CYCLES > 1) ? $clog2(BUS_TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUS_TIMEOUT_CYCLES - 1);

    state_e           state, state_nxt;
    instr_decoded_t   ctl_q;
    logic [31:0]      addr_q, rs2_q, next_pc_q;
    logic [CNT_W-1:0] tmo_cnt;
    operation_e       op_in;
    logic             accept, mem_in, trap_in, tmo_hit, st_q;
    logic             done_ok, done_fault;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata, lane_load;

    assign op_in   = operation_e'(operation_i);
    assign ready_o = (state == S_IDLE);
    assign accept  = valid_i && ready_o;
    assign mem_in  = is_mem_op(op_in);
    assign st_q    = op_is_store(ctl_q.operation);
    assign tmo_hit = TMO_EN && (state != S_IDLE) && (tmo_cnt == TMO_LAST);

`ifdef KAMUS_MISALIGN_TRAP_EN
    assign trap_in = mem_in && is_misaligned(op_size(op_in), ex_i[1:0]);
`else
    assign trap_in = 1'b0;
`endif

    kamus_lsu_align u_align (
        .size        (op_size(ctl_q.operation)),
        .store       (st_q),
        .unsigned_ld (op_is_unsigned(ctl_q.operation)),
        .addr_lo     (addr_q[1:0]),
        .store_data  (rs2_q),
        .rdata       (dmem_rdata_i),
        .be          (lane_be),
        .wdata       (lane_wdata),
        .load_data   (lane_load)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state, bus outputs and completion qualifiers.
    always_comb begin
        state_nxt    = state;
        done_ok      = 1'b0;
        done_fault   = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_be_o    = 4'h0;
        dmem_addr_o  = 32'h0;
        dmem_wdata_o = 32'h0;
        case (state)
            S_IDLE: begin
                if (accept && mem_in && !trap_in) state_nxt = S_REQ;
            end
            S_REQ: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = ctl_q.l1d_wr_en;
                dmem_be_o    = lane_be;
                dmem_addr_o  = {addr_q[31:2], 2'b00};
                dmem_wdata_o = lane_wdata;
                if (tmo_hit) begin
                    state_nxt  = S_IDLE;
                    done_fault = 1'b1;
                end else if (dmem_gnt_i) begin
                    state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                if (dmem_rvalid_i) begin
                    state_nxt  = S_IDLE;
                    done_fault = dmem_err_i;
                    done_ok    = !dmem_err_i;
                end else if (tmo_hit) begin
                    state_nxt  = S_IDLE;
                    done_fault = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus timeout counter, running only while an access is outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                      tmo_cnt <= '0;
        else if (state == S_IDLE || state_nxt == S_IDLE) tmo_cnt <= '0;
        else if (TMO_EN)                                tmo_cnt <= tmo_cnt + CNT_W'(1);
    end

    // Latch the memory op and its control fields on accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctl_q     <= '0;
            addr_q    <= 32'h0;
            rs2_q     <= 32'h0;
            next_pc_q <= 32'h0;
        end else if (accept && mem_in && !trap_in) begin
            ctl_q     <= '{operation: op_in, rd_addr: rd_addr_i, regfile_wr_en: regfile_wr_en_i,
                           wb_mux_sel: wb_mux_sel_i, l1d_wr_en: l1d_wr_en_i};
            addr_q    <= ex_i;
            rs2_q     <= rs2_data_i;
            next_pc_q <= next_pc_i;
        end
    end

    // Writeback registers: immediate retire from IDLE, or access completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_o         <= 1'b0;
            wb_rd_addr_o       <= 5'h0;
            wb_regfile_wr_en_o <= 1'b0;
            wb_mux_sel_o       <= 2'h0;
            wb_ex_o            <= 32'h0;
            wb_load_data_o     <= 32'h0;
            wb_next_pc_o       <= 32'h0;
            exc_o              <= 1'b0;
            exc_cause_o        <= 4'h0;
            exc_addr_o         <= 32'h0;
        end else begin
            wb_valid_o <= 1'b0;
            exc_o      <= 1'b0;
            if (accept && (!mem_in || trap_in)) begin
                wb_valid_o         <= 1'b1;
                wb_rd_addr_o       <= rd_addr_i;
                wb_regfile_wr_en_o <= regfile_wr_en_i && !trap_in;
                wb_mux_sel_o       <= wb_mux_sel_i;
                wb_ex_o            <= ex_i;
                wb_load_data_o     <= 32'h0;
                wb_next_pc_o       <= next_pc_i;
                exc_o              <= trap_in;
                exc_cause_o        <= !trap_in ? 4'h0 :
                                      op_is_store(op_in) ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
                exc_addr_o         <= trap_in ? ex_i : 32'h0;
            end else if (done_ok || done_fault) begin
                wb_valid_o         <= 1'b1;
                wb_rd_addr_o       <= ctl_q.rd_addr;
                wb_regfile_wr_en_o <= ctl_q.regfile_wr_en && !done_fault;
                wb_mux_sel_o       <= ctl_q.wb_mux_sel;
                wb_ex_o            <= addr_q;
                wb_load_data_o     <= (st_q || done_fault) ? 32'h0 : lane_load;
                wb_next_pc_o       <= next_pc_q;
                exc_o              <= done_fault;
                exc_cause_o        <= !done_fault ? 4'h0 : st_q ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
                exc_addr_o         <= done_fault ? addr_q : 32'h0;
            end
        end
    end

endmodule
